// File: rtl/cnt_pkg.sv
// cnt_pkg: state encoding and default width shared by the up/down counter family
package cnt_pkg;
    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN = 1'b1;
    localparam int CNT_WIDTH_DEF = 4;
endpackage

// File: rtl/cnt_dn_load.sv
// cnt_dn_load: loadable down-counting timer with one-shot/periodic reload and registered underflow pulse
module cnt_dn_load
    import cnt_pkg::*;
#(
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 load_i,
    input  logic [CNT_WIDTH-1:0] load_val_i,
    input  logic                 cnt_en_i,
    input  logic                 cnt_clr_i,
    input  logic                 periodic_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 busy_o,
    output logic                 udf_o
);
    logic                 state;
    logic [CNT_WIDTH-1:0] reload;
    logic                 udf_now;
    assign udf_now = state == ST_RUN && cnt_en_i && cnt_o == '0;
    assign busy_o = state == ST_RUN;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_o <= '0;
            reload <= '0;
            udf_o <= 1'b0;
            state <= ST_IDLE;
        end else if (cnt_clr_i) begin
            cnt_o <= '0;
            udf_o <= 1'b0;
            state <= ST_IDLE;
        end else if (load_i) begin
            cnt_o <= load_val_i;
            reload <= load_val_i;
            udf_o <= 1'b0;
            state <= ST_RUN;
        end else if (udf_now) begin
            // zero is the underflow point, so the decrement below never wraps
            cnt_o <= periodic_i ? reload : '0;
            udf_o <= 1'b1;
            state <= periodic_i ? ST_RUN : ST_IDLE;
        end else begin
            cnt_o <= (state == ST_RUN && cnt_en_i) ? cnt_o - CNT_WIDTH'(1) : cnt_o;
            udf_o <= 1'b0;
        end
    end
endmodule

// File: tb/tb_cnt_dn_load.sv
// tb_cnt_dn_load: directed scenario tasks with hand-computed expectations for cnt_dn_load
module tb_cnt_dn_load;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic       en = 1'b0;
    logic       clr = 1'b0;
    logic       periodic = 1'b0;
    logic [3:0] cnt;
    logic       busy;
    logic       udf;
    int         nvec = 0;
    int         nerr = 0;

    cnt_dn_load dut (
        .clk_i(clk), .rst_i(rst), .load_i(load), .load_val_i(load_val),
        .cnt_en_i(en), .cnt_clr_i(clr), .periodic_i(periodic),
        .cnt_o(cnt), .busy_o(busy), .udf_o(udf)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            nvec++;
            if (cnt !== 4'd0 || busy !== 1'b0 || udf !== 1'b0) begin
                nerr++;
                $display("FAIL reset[%0d]: cnt=%0d busy=%b udf=%b, want 0 0 0", i, cnt, busy, udf);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            nvec++;
            if (cnt !== 4'd0 || busy !== 1'b0 || udf !== 1'b0) begin
                nerr++;
                $display("FAIL post_reset[%0d]: cnt=%0d busy=%b udf=%b, want 0 0 0", i, cnt, busy, udf);
            end
        end
    endtask

    task automatic test_oneshot;
        logic [3:0] ec [4] = '{4'd3, 4'd2, 4'd1, 4'd0};
        periodic = 1'b0;
        en = 1'b1;
        load = 1'b1;
        load_val = 4'd3;
        for (int i = 0; i < 4; i++) begin
            tick();
            load = 1'b0;
            nvec++;
            if (cnt !== ec[i] || busy !== 1'b1 || udf !== 1'b0) begin
                nerr++;
                $display("FAIL oneshot[%0d]: cnt=%0d busy=%b udf=%b, want %0d 1 0", i, cnt, busy, udf, ec[i]);
            end
        end
        tick();
        nvec++;
        if (cnt !== 4'd0 || busy !== 1'b0 || udf !== 1'b1) begin
            nerr++;
            $display("FAIL oneshot_udf: cnt=%0d busy=%b udf=%b, want 0 0 1", cnt, busy, udf);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            nvec++;
            if (cnt !== 4'd0 || busy !== 1'b0 || udf !== 1'b0) begin
                nerr++;
                $display("FAIL oneshot_quiet[%0d]: cnt=%0d busy=%b udf=%b, want 0 0 0", i, cnt, busy, udf);
            end
        end
    endtask

    task automatic test_periodic;
        logic [3:0] ec [9] = '{4'd1, 4'd0, 4'd2, 4'd1, 4'd0, 4'd2, 4'd1, 4'd0, 4'd2};
        logic       eu [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        periodic = 1'b1;
        en = 1'b1;
        load = 1'b1;
        load_val = 4'd2;
        tick();
        load = 1'b0;
        nvec++;
        if (cnt !== 4'd2 || busy !== 1'b1 || udf !== 1'b0) begin
            nerr++;
            $display("FAIL periodic_load: cnt=%0d busy=%b udf=%b, want 2 1 0", cnt, busy, udf);
        end
        for (int i = 0; i < 9; i++) begin
            tick();
            nvec++;
            if (cnt !== ec[i] || busy !== 1'b1 || udf !== eu[i]) begin
                nerr++;
                $display("FAIL periodic[%0d]: cnt=%0d busy=%b udf=%b, want %0d 1 %b", i, cnt, busy, udf, ec[i], eu[i]);
            end
        end
    endtask

    task automatic test_enable_gaps;
        int e = 0;
        logic [3:0] want;
        logic wu;
        periodic = 1'b1;
        load = 1'b1;
        load_val = 4'd4;
        tick();
        load = 1'b0;
        for (int t = 1; t <= 20; t++) begin
            en = t[0];
            tick();
            if (t[0]) e++;
            want = 4'(4 - (e % 5));
            wu = t[0] && (e % 5 == 0);
            nvec++;
            if (cnt !== want || busy !== 1'b1 || udf !== wu) begin
                nerr++;
                $display("FAIL gaps[%0d]: cnt=%0d busy=%b udf=%b, want %0d 1 %b", t, cnt, busy, udf, want, wu);
            end
        end
        en = 1'b1;
    endtask

    task automatic test_simultaneous;
        clr = 1'b1;
        load = 1'b1;
        load_val = 4'd5;
        tick();
        clr = 1'b0;
        load = 1'b0;
        nvec++;
        if (cnt !== 4'd0 || busy !== 1'b0 || udf !== 1'b0) begin
            nerr++;
            $display("FAIL clr_load: cnt=%0d busy=%b udf=%b, want 0 0 0", cnt, busy, udf);
        end
        periodic = 1'b1;
        en = 1'b1;
        load = 1'b1;
        load_val = 4'd0;
        tick();
        load = 1'b0;
        nvec++;
        if (cnt !== 4'd0 || busy !== 1'b1 || udf !== 1'b0) begin
            nerr++;
            $display("FAIL load0: cnt=%0d busy=%b udf=%b, want 0 1 0", cnt, busy, udf);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            nvec++;
            if (cnt !== 4'd0 || busy !== 1'b1 || udf !== 1'b1) begin
                nerr++;
                $display("FAIL load0_udf[%0d]: cnt=%0d busy=%b udf=%b, want 0 1 1", i, cnt, busy, udf);
            end
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        nvec++;
        if (cnt !== 4'd0 || busy !== 1'b0 || udf !== 1'b0) begin
            nerr++;
            $display("FAIL clr_udf: cnt=%0d busy=%b udf=%b, want 0 0 0", cnt, busy, udf);
        end
        load = 1'b1;
        tick();
        load = 1'b0;
        tick();
        nvec++;
        if (cnt !== 4'd0 || busy !== 1'b1 || udf !== 1'b1) begin
            nerr++;
            $display("FAIL reload0_udf: cnt=%0d busy=%b udf=%b, want 0 1 1", cnt, busy, udf);
        end
        load = 1'b1;
        load_val = 4'd7;
        tick();
        load = 1'b0;
        nvec++;
        if (cnt !== 4'd7 || busy !== 1'b1 || udf !== 1'b0) begin
            nerr++;
            $display("FAIL load_on_udf: cnt=%0d busy=%b udf=%b, want 7 1 0", cnt, busy, udf);
        end
    endtask

    task automatic test_midrun_reset_wrap;
        logic [3:0] want;
        periodic = 1'b1;
        en = 1'b1;
        load = 1'b1;
        load_val = 4'd15;
        tick();
        load = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        nvec++;
        if (cnt !== 4'd10 || busy !== 1'b1) begin
            nerr++;
            $display("FAIL pre_reset: cnt=%0d busy=%b, want 10 1", cnt, busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        nvec++;
        if (cnt !== 4'd0 || busy !== 1'b0 || udf !== 1'b0) begin
            nerr++;
            $display("FAIL midrun_reset: cnt=%0d busy=%b udf=%b, want 0 0 0", cnt, busy, udf);
        end
        tick();
        nvec++;
        if (cnt !== 4'd0 || busy !== 1'b0 || udf !== 1'b0) begin
            nerr++;
            $display("FAIL idle_en: cnt=%0d busy=%b udf=%b, want 0 0 0", cnt, busy, udf);
        end
        load = 1'b1;
        tick();
        load = 1'b0;
        for (int t = 1; t <= 32; t++) begin
            tick();
            want = 4'(15 - (t % 16));
            nvec++;
            if (cnt !== want || busy !== 1'b1 || udf !== (t % 16 == 0)) begin
                nerr++;
                $display("FAIL wrap[%0d]: cnt=%0d busy=%b udf=%b, want %0d 1 %b", t, cnt, busy, udf, want, t % 16 == 0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_periodic();
        test_enable_gaps();
        test_simultaneous();
        test_midrun_reset_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
